// File: rtl/telem_frame_buffer.sv
// Telemetry frame buffer: shadow bank, snapshot-on-commit frame bank, ready/valid word streamer.
// Optional trailing checksum word when TELEM_CHECKSUM_EN is defined.
module telem_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

`ifdef TELEM_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_t;
`else
  typedef enum logic {S_IDLE, S_SEND} state_t;
`endif

  logic [DATA_W-1:0] r_shadow [NUM_CH];
  logic [DATA_W-1:0] r_frame  [NUM_CH];
  logic [DATA_W-1:0] w_snap   [NUM_CH];
  logic [IDX_W-1:0]  r_idx;
  state_t            r_state;
  logic              r_overrun;
  logic              w_hs_last;
  logic              w_accept;
  logic [DATA_W-1:0] w_out_data;

  // Shadow contents with this cycle's write applied; out-of-range addresses match no channel.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_snap[i] = r_shadow[i];
      if (wr_en && (wr_addr == ADDR_W'(i)))
        w_snap[i] = wr_data;
    end
  end

`ifdef TELEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] w_snap_sum;

  always_comb begin
    w_snap_sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      w_snap_sum = w_snap_sum + w_snap[i];
  end

  assign w_hs_last = out_ready && (r_state == S_CSUM);
`else
  assign w_hs_last = out_ready && (r_state == S_SEND) && (r_idx == LAST_IDX);
`endif

  assign w_accept = commit && ((r_state == S_IDLE) || w_hs_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_frame[i]  <= '0;
      end
      r_idx     <= '0;
      r_state   <= S_IDLE;
      r_overrun <= 1'b0;
`ifdef TELEM_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_overrun <= commit && !w_accept;
      for (int unsigned i = 0; i < NUM_CH; i++)
        r_shadow[i] <= w_snap[i];

      if (w_accept) begin
        for (int unsigned i = 0; i < NUM_CH; i++)
          r_frame[i] <= w_snap[i];
        r_idx   <= '0;
        r_state <= S_SEND;
`ifdef TELEM_CHECKSUM_EN
        r_csum  <= w_snap_sum;
`endif
      end else begin
        case (r_state)
          S_SEND: begin
            if (out_ready) begin
              if (r_idx == LAST_IDX) begin
                r_idx <= '0;
`ifdef TELEM_CHECKSUM_EN
                r_state <= S_CSUM;
`else
                r_state <= S_IDLE;
`endif
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
`ifdef TELEM_CHECKSUM_EN
          S_CSUM: begin
            if (out_ready)
              r_state <= S_IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_out_data = '0;
    if (r_state == S_SEND)
      w_out_data = r_frame[r_idx];
`ifdef TELEM_CHECKSUM_EN
    else if (r_state == S_CSUM)
      w_out_data = r_csum;
`endif
  end

  assign out_valid = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = w_out_data;
  assign overrun   = r_overrun;
`ifdef TELEM_CHECKSUM_EN
  assign out_last  = (r_state == S_CSUM);
`else
  assign out_last  = (r_state == S_SEND) && (r_idx == LAST_IDX);
`endif

endmodule

// File: tb/tb_telem_frame_buffer.sv
// Testbench for telem_frame_buffer: directed scenarios plus random traffic against a
// queue-of-words frame model; honours TELEM_CHECKSUM_EN.
module tb_telem_frame_buffer;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int AW = 5;
`ifdef TELEM_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          commit;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          overrun;

  telem_frame_buffer #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_shadow [NC];
  logic [DW-1:0] m_q [$];
  bit            m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    chk("busy",      {31'b0, busy},      {31'b0, m_q.size() > 0});
    chk("out_data",  {24'b0, out_data},  (m_q.size() > 0) ? {24'b0, m_q[0]} : 32'h0);
    chk("out_last",  {31'b0, out_last},  {31'b0, m_q.size() == 1});
    chk("overrun",   {31'b0, overrun},   {31'b0, m_ovr});
  endtask

  // Frame-level model: the frame in flight is the queue of words still to be accepted.
  task automatic model_edge(input bit we, input int unsigned addr, input logic [DW-1:0] d,
                            input bit cm, input bit rdy);
    logic [DW-1:0] snap [NC];
    logic [DW-1:0] sum;
    int  n;
    bit  hs;
    bit  acc;
    n   = m_q.size();
    hs  = (n > 0) && rdy;
    acc = cm && ((n == 0) || (hs && n == 1));
    snap = m_shadow;
    if (we && addr < NC) snap[addr] = d;
    if (hs) void'(m_q.pop_front());
    if (acc) begin
      m_q.delete();
      sum = '0;
      for (int i = 0; i < NC; i++) begin
        m_q.push_back(snap[i]);
        sum = sum + snap[i];
      end
      if (CS) m_q.push_back(sum);
    end
    m_ovr    = cm && !acc;
    m_shadow = snap;
  endtask

  task automatic step(input bit we, input int unsigned addr, input logic [DW-1:0] d,
                      input bit cm, input bit rdy);
    wr_en = we; wr_addr = AW'(addr); wr_data = d; commit = cm; out_ready = rdy;
    @(posedge clk);
    model_edge(we, addr, d, cm, rdy);
    #1 check_outputs();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, '0, 1'b0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_q.size() > 0; i++) idle(1'b1);
    chk("drain_done", {31'b0, out_valid}, 32'h0);
  endtask

  // Reset is raised between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid",   {31'b0, out_valid}, 32'h0);
    chk("rst_data",    {24'b0, out_data},  32'h0);
    chk("rst_last",    {31'b0, out_last},  32'h0);
    chk("rst_busy",    {31'b0, busy},      32'h0);
    chk("rst_overrun", {31'b0, overrun},   32'h0);
    for (int i = 0; i < NC; i++) m_shadow[i] = '0;
    m_q.delete();
    m_ovr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NC; i++) m_shadow[i] = '0;
    m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1 pulse_reset();

    // Basic frame with continuous ready
    step(1'b1, 0, 8'h11, 1'b0, 1'b1);
    step(1'b1, 1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 2, 8'h33, 1'b0, 1'b1);
    step(1'b1, 3, 8'h44, 1'b0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1);
    chk("first_word_latency1", {24'b0, out_data}, 32'h11);
    drain();

    // Same frame with ready stalls 1,0,0,1
    step(1'b0, 0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 24 && m_q.size() > 0; i++) idle((i % 4 == 0) || (i % 4 == 3));
    chk("stall_done", {31'b0, out_valid}, 32'h0);

    // Commit mid-frame is dropped; a following shadow write does not disturb the frame
    step(1'b0, 0, '0, 1'b1, 1'b1);
    idle(1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1);
    chk("overrun_pulse", {31'b0, overrun}, 32'h1);
    step(1'b1, 0, 8'h55, 1'b0, 1'b1);
    chk("overrun_once", {31'b0, overrun}, 32'h0);
    drain();
    step(1'b0, 0, '0, 1'b1, 1'b0);
    chk("new_ch0_first", {24'b0, out_data}, 32'h55);
    drain();

    // Back-to-back frames: commit on the final handshake with ch1 rewritten
    step(1'b0, 0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10 && m_q.size() > 1; i++) idle(1'b1);
    step(1'b1, 1, 8'h99, 1'b1, 1'b1);
    chk("b2b_no_overrun", {31'b0, overrun}, 32'h0);
    chk("b2b_valid_held", {31'b0, out_valid}, 32'h1);
    idle(1'b1);
    chk("b2b_second_word", {24'b0, out_data}, 32'h99);
    drain();

    // Out-of-range write is ignored
    step(1'b1, 7, 8'hFF, 1'b0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1);
    drain();

    // Reset after the second word of a frame, then an all-zero frame
    step(1'b0, 0, '0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    pulse_reset();
    step(1'b0, 0, '0, 1'b1, 1'b1);
    chk("post_rst_word0", {24'b0, out_data}, 32'h0);
    drain();

    // Random traffic, including occasional mid-stream reset
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset();
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), DW'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
